// File: rtl/hazard_ctrl_pkg.sv
// Hazard-sequencer slice of the rv32i_types definitions: opcode constant and FSM state encoding.
package hazard_ctrl_pkg;

    localparam logic [6:0] op_load = 7'b0000011;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2,
        LU_STALL = 2'd3
    } hazard_state_t;

endpackage

// File: rtl/hazard_ctrl_perf_cnt.sv
// Pair of saturating performance counters (stall cycles, flush entries).
module hazard_perf_cnt #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall_evt,
    input  logic             flush_evt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush sequencer for the 5-stage RV32I core.
// Optional performance counters enabled by defining HAZARD_PERF_CNT_EN.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1_s,
    input  logic [4:0]       id_rs2_s,
    input  logic             ex_valid,
    input  logic [6:0]       ex_opcode,
    input  logic [4:0]       ex_rd_s,
    input  logic             ex_redirect,
    input  logic             imem_wait,
    input  logic             dmem_wait,
    output logic             stall_signal,
    output logic             freeze_stall,
    output logic             flushing_inst,
    output logic             bubble_ex,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] perf_stall_cnt,
    output logic [CNT_W-1:0] perf_flush_cnt
);

    localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    hazard_state_t state, next_state;
    logic [2:0]    flush_cnt, flush_cnt_next;
    logic          pending_redirect, pending_next;
    logic          lu;

    assign lu = id_valid && ex_valid && (ex_opcode == op_load) && (ex_rd_s != 5'd0) &&
                ((ex_rd_s == id_rs1_s) || (ex_rd_s == id_rs2_s));

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= RUN;
            flush_cnt        <= '0;
            pending_redirect <= 1'b0;
        end else begin
            state            <= next_state;
            flush_cnt        <= flush_cnt_next;
            pending_redirect <= pending_next;
        end
    end

    always_comb begin
        next_state     = state;
        flush_cnt_next = flush_cnt;
        pending_next   = pending_redirect;
        case (state)
            RUN, LU_STALL: begin
                // a redirect coinciding with a memory wait is parked, not dropped
                if (dmem_wait) begin
                    next_state   = MEM_WAIT;
                    pending_next = ex_redirect;
                end else if (ex_redirect) begin
                    next_state     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                end else if (lu && (state == RUN)) begin
                    next_state = LU_STALL;
                end else begin
                    next_state = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_wait) begin
                    if (ex_redirect) pending_next = 1'b1;
                end else if (pending_redirect || ex_redirect) begin
                    next_state     = FLUSH;
                    flush_cnt_next = FLUSH_LOAD;
                    pending_next   = 1'b0;
                end else begin
                    next_state = RUN;
                end
            end
            FLUSH: begin
                // the squash window is held, not consumed, while memory is frozen
                if (ex_redirect) begin
                    flush_cnt_next = FLUSH_LOAD;
                end else if (dmem_wait) begin
                    flush_cnt_next = flush_cnt;
                end else if (flush_cnt == 3'd0) begin
                    next_state = RUN;
                end else begin
                    flush_cnt_next = flush_cnt - 3'd1;
                end
            end
            default: next_state = RUN;
        endcase
    end

    assign stall_signal  = (state == LU_STALL) && !ex_redirect;
    assign freeze_stall  = dmem_wait || imem_wait || (state == MEM_WAIT);
    assign flushing_inst = (state == FLUSH);
    assign bubble_ex     = (state == FLUSH) || (state == LU_STALL);
    assign state_o       = state;

`ifdef HAZARD_PERF_CNT_EN
    logic flush_evt;
    assign flush_evt = (next_state == FLUSH) && ((state != FLUSH) || ex_redirect);

    hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
        .clk       (clk),
        .rst       (rst),
        .stall_evt (stall_signal || freeze_stall),
        .flush_evt (flush_evt),
        .stall_cnt (perf_stall_cnt),
        .flush_cnt (perf_flush_cnt)
    );
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl plus hand sequences for memory-wait and reset corners.
module tb_hazard_ctrl;

    localparam logic [6:0] LD  = 7'b0000011;
    localparam logic [6:0] ALU = 7'b0110011;
    localparam logic [1:0] S_RUN = 2'd0, S_MEM = 2'd1, S_FL = 2'd2, S_LU = 2'd3;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, id_valid, ex_valid, ex_redirect, imem_wait, dmem_wait;
    logic [4:0]  id_rs1_s, id_rs2_s, ex_rd_s;
    logic [6:0]  ex_opcode;
    logic        stall_signal, freeze_stall, flushing_inst, bubble_ex;
    logic [1:0]  state_o;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .id_valid       (id_valid),
        .id_rs1_s       (id_rs1_s),
        .id_rs2_s       (id_rs2_s),
        .ex_valid       (ex_valid),
        .ex_opcode      (ex_opcode),
        .ex_rd_s        (ex_rd_s),
        .ex_redirect    (ex_redirect),
        .imem_wait      (imem_wait),
        .dmem_wait      (dmem_wait),
        .stall_signal   (stall_signal),
        .freeze_stall   (freeze_stall),
        .flushing_inst  (flushing_inst),
        .bubble_ex      (bubble_ex),
        .state_o        (state_o),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    typedef struct {
        logic       rst, idv;
        logic [4:0] rs1, rs2;
        logic       exv;
        logic [6:0] op;
        logic [4:0] rd;
        logic       redir, imem, dmem;
        logic [3:0] exp_o;   // {stall, freeze, flush, bubble}
        logic [1:0] exp_st;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic r, input logic iv, input logic [4:0] a, input logic [4:0] b,
                               input logic xv, input logic [6:0] op, input logic [4:0] rd,
                               input logic rdr, input logic im, input logic dm,
                               input logic [3:0] eo, input logic [1:0] es);
        vec_t t;
        t.rst = r; t.idv = iv; t.rs1 = a; t.rs2 = b; t.exv = xv; t.op = op; t.rd = rd;
        t.redir = rdr; t.imem = im; t.dmem = dm; t.exp_o = eo; t.exp_st = es;
        return t;
    endfunction

    function automatic vec_t idle(input logic [3:0] eo, input logic [1:0] es);
        return v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, eo, es);
    endfunction

    function automatic vec_t lu_in(input logic rdr, input logic dm, input logic [3:0] eo, input logic [1:0] es);
        return v(0, 1, 5, 2, 1, LD, 5, rdr, 0, dm, eo, es);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input vec_t t);
        rst = t.rst; id_valid = t.idv; id_rs1_s = t.rs1; id_rs2_s = t.rs2; ex_valid = t.exv;
        ex_opcode = t.op; ex_rd_s = t.rd; ex_redirect = t.redir; imem_wait = t.imem; dmem_wait = t.dmem;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] eo, input logic [1:0] es);
        chk({tag, ".stall"},  {31'd0, stall_signal},  {31'd0, eo[3]});
        chk({tag, ".freeze"}, {31'd0, freeze_stall},  {31'd0, eo[2]});
        chk({tag, ".flush"},  {31'd0, flushing_inst}, {31'd0, eo[1]});
        chk({tag, ".bubble"}, {31'd0, bubble_ex},     {31'd0, eo[0]});
        chk({tag, ".state"},  {30'd0, state_o},       {30'd0, es});
    endtask

    task automatic do_reset();
        drive(idle(4'b0000, S_RUN));
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // load-use stall, then non-hazards (x0, unrelated regs, ID invalid, non-load, EX invalid)
        tbl.push_back(lu_in(0, 0, 4'b0000, S_RUN));
        tbl.push_back(idle(4'b1001, S_LU));
        tbl.push_back(idle(4'b0000, S_RUN));
        tbl.push_back(v(0, 1, 0, 0, 1, LD, 0, 0, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 1, 7, 8, 1, LD, 5, 0, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 0, 5, 5, 1, LD, 5, 0, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 1, 5, 5, 1, ALU, 5, 0, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 1, 9, 5, 0, LD, 5, 0, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(idle(4'b0000, S_RUN));
        // redirect: two flush cycles
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));
        // redirect and lu together: redirect wins
        tbl.push_back(lu_in(1, 0, 4'b0000, S_RUN));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));
        // redirect arriving in LU_STALL drops stall, keeps bubble
        tbl.push_back(lu_in(0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'b0001, S_LU));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));
        // imem_wait alone: freeze without state change
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'b0100, S_RUN));
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'b0100, S_RUN));
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 1, 0, 4'b0100, S_RUN));
        tbl.push_back(idle(4'b0000, S_RUN));
        // redirect in FLUSH reloads the counter
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));
        // dmem_wait during LU_STALL
        tbl.push_back(lu_in(0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 0, 0, 1, 4'b1101, S_LU));
        tbl.push_back(idle(4'b0100, S_MEM));
        tbl.push_back(idle(4'b0000, S_RUN));
        // reset mid-FLUSH
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 0, 4'b0000, S_RUN));
        tbl.push_back(v(1, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));
        // dmem_wait and redirect in the same cycle: redirect parked until wait ends
        tbl.push_back(v(0, 0, 0, 0, 0, ALU, 0, 1, 0, 1, 4'b0100, S_RUN));
        tbl.push_back(idle(4'b0100, S_MEM));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0011, S_FL));
        tbl.push_back(idle(4'b0000, S_RUN));

        do_reset();
        chk_outs("reset", 4'b0000, S_RUN);
        chk("reset.perf_stall", perf_stall_cnt, 32'd0);
        chk("reset.perf_flush", perf_flush_cnt, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            #2;
            chk_outs($sformatf("row%0d", i), tbl[i].exp_o, tbl[i].exp_st);
            tick();
        end

        // dmem_wait 5 cycles with redirect in cycle 2, then two flush cycles
        do_reset();
        for (int c = 1; c <= 5; c++) begin
            drive(idle(4'b0000, S_RUN));
            dmem_wait = 1'b1;
            ex_redirect = (c == 2);
            #2;
            chk($sformatf("mw.c%0d.freeze", c), {31'd0, freeze_stall}, 32'd1);
            chk($sformatf("mw.c%0d.state", c), {30'd0, state_o}, (c == 1) ? 32'(S_RUN) : 32'(S_MEM));
            chk($sformatf("mw.c%0d.flush", c), {31'd0, flushing_inst}, 32'd0);
            tick();
        end
        drive(idle(4'b0000, S_RUN));
        #2;
        chk("mw.c6.state", {30'd0, state_o}, 32'(S_MEM));
        chk("mw.c6.flush", {31'd0, flushing_inst}, 32'd0);
        tick();
        chk_outs("mw.c7", 4'b0011, S_FL);
        tick();
        chk_outs("mw.c8", 4'b0011, S_FL);
        tick();
        chk_outs("mw.c9", 4'b0000, S_RUN);
        chk("mw.perf_stall", perf_stall_cnt, PERF ? 32'd6 : 32'd0);
        chk("mw.perf_flush", perf_flush_cnt, PERF ? 32'd1 : 32'd0);

        // redirect counted on flush entry, then reset in FLUSH cycle 1
        ex_redirect = 1'b1;
        #1;
        chk("rd.perf_flush_before", perf_flush_cnt, PERF ? 32'd1 : 32'd0);
        tick();
        ex_redirect = 1'b0;
        rst = 1'b1;
        #1;
        chk("rd.flush_c1", {31'd0, flushing_inst}, 32'd1);
        chk("rd.perf_flush_after", perf_flush_cnt, PERF ? 32'd2 : 32'd0);
        tick();
        rst = 1'b0;
        #1;
        chk_outs("rst_flush", 4'b0000, S_RUN);
        chk("rst_flush.perf_stall", perf_stall_cnt, 32'd0);
        chk("rst_flush.perf_flush", perf_flush_cnt, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
